// File: rtl/fht_stream_loader.sv
// Stream-to-RAM loader for the FHT core. It scatters one frame of 4*2^A_BIT samples across
// the four RAM(A) banks, zero-pads short frames, then sends a start strobe and waits for the core.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LOAD  | accepting samples, one write per accepted sample
// S_PAD   | writing zeros to the remaining indices of a short frame
// S_START | final write visible on oWE; raise oSTART and clear n
// S_WAIT  | core running; hold off input until iRDY (after guard window)
module fht_stream_loader #(
   parameter int D_BIT   = 16,
   parameter int A_BIT   = 8,
   parameter int BIT_REV = 1
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic signed [D_BIT-1:0] iDATA,
   input  logic                    iVALID,
   input  logic                    iLAST,
   output logic                    oREADY,
   input  logic                    iRDY,
   output logic        [3:0]       oWE,
   output logic signed [D_BIT-1:0] oDATA_0,
   output logic signed [D_BIT-1:0] oDATA_1,
   output logic signed [D_BIT-1:0] oDATA_2,
   output logic signed [D_BIT-1:0] oDATA_3,
   output logic        [A_BIT-1:0] oADDR_WR_0,
   output logic        [A_BIT-1:0] oADDR_WR_1,
   output logic        [A_BIT-1:0] oADDR_WR_2,
   output logic        [A_BIT-1:0] oADDR_WR_3,
   output logic                    oSTART,
   output logic                    oBUSY,
   output logic                    oERR_LEN
);

   localparam int N_BIT = A_BIT + 2;
   localparam logic [N_BIT-1:0] N_LAST = {N_BIT{1'b1}};

   typedef enum logic [1:0] {
      S_LOAD,
      S_PAD,
      S_START,
      S_WAIT
   } state_t;

   state_t                    state;
   logic       [N_BIT-1:0]    n;
   logic       [1:0]          hold_cnt;
   logic       [N_BIT-1:0]    r_idx;
   logic       [1:0]          wr_bank;
   logic       [A_BIT-1:0]    wr_addr;
   logic signed [D_BIT-1:0]   wr_data;
   logic                      accept;
   logic                      do_wr;

   assign oREADY = (state == S_LOAD);
   assign accept = iVALID & oREADY;
   assign do_wr  = accept | (state == S_PAD);

   always_comb begin
      r_idx = n;
      if (BIT_REV != 0) begin
         for (int i = 0; i < N_BIT; i++) begin
            r_idx[i] = n[N_BIT-1-i];
         end
      end
   end

   assign wr_bank = r_idx[1:0];
   assign wr_addr = r_idx[N_BIT-1:2];
   assign wr_data = (state == S_PAD) ? '0 : iDATA;

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         state      <= S_LOAD;
         n          <= '0;
         hold_cnt   <= '0;
         oWE        <= '0;
         oDATA_0    <= '0;
         oDATA_1    <= '0;
         oDATA_2    <= '0;
         oDATA_3    <= '0;
         oADDR_WR_0 <= '0;
         oADDR_WR_1 <= '0;
         oADDR_WR_2 <= '0;
         oADDR_WR_3 <= '0;
         oSTART     <= 1'b0;
         oBUSY      <= 1'b0;
         oERR_LEN   <= 1'b0;
      end else begin
         oWE      <= '0;
         oSTART   <= 1'b0;
         oERR_LEN <= 1'b0;

         // Address and data only move on a write so the core sees stable buses otherwise.
         if (do_wr) begin
            oWE        <= 4'b0001 << wr_bank;
            oDATA_0    <= wr_data;
            oDATA_1    <= wr_data;
            oDATA_2    <= wr_data;
            oDATA_3    <= wr_data;
            oADDR_WR_0 <= wr_addr;
            oADDR_WR_1 <= wr_addr;
            oADDR_WR_2 <= wr_addr;
            oADDR_WR_3 <= wr_addr;
         end

         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (n == N_LAST) begin
                     state    <= S_START;
                     oBUSY    <= 1'b1;
                     oERR_LEN <= ~iLAST;
                  end else if (iLAST) begin
                     state    <= S_PAD;
                     oERR_LEN <= 1'b1;
                     n        <= n + 1'b1;
                  end else begin
                     n <= n + 1'b1;
                  end
               end
            end
            S_PAD: begin
               if (n == N_LAST) begin
                  state <= S_START;
                  oBUSY <= 1'b1;
               end else begin
                  n <= n + 1'b1;
               end
            end
            S_START: begin
               oSTART   <= 1'b1;
               n        <= '0;
               hold_cnt <= 2'd2;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // The core's oRDY is stale for two cycles after the strobe.
               if (hold_cnt != 2'd0) begin
                  hold_cnt <= hold_cnt - 2'd1;
               end else if (iRDY) begin
                  state <= S_LOAD;
                  oBUSY <= 1'b0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fht_stream_loader.sv
// Directed bench for fht_stream_loader with A_BIT=2: one bit-reversed and one natural-order
// instance driven by the same stream, expected bank/address/data from hand tables.
module tb_fht_stream_loader;

   logic               iCLK = 1'b0;
   logic               iRESET;
   logic signed [15:0] iDATA;
   logic               iVALID;
   logic               iLAST;
   logic               iRDY;

   logic               ready_r, start_r, busy_r, err_r;
   logic [3:0]         we_r;
   logic signed [15:0] d0_r, d1_r, d2_r, d3_r;
   logic [1:0]         a0_r, a1_r, a2_r, a3_r;

   logic               ready_n, start_n, busy_n, err_n;
   logic [3:0]         we_n;
   logic signed [15:0] d0_n, d1_n, d2_n, d3_n;
   logic [1:0]         a0_n, a1_n, a2_n, a3_n;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int err_cnt = 0;
   int fan_err = 0;
   int r_we[$], r_addr[$], r_data[$], r_cyc[$];
   int n_we[$], n_addr[$], n_data[$];
   int rev_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fht_stream_loader #(.D_BIT(16), .A_BIT(2), .BIT_REV(1)) u_rev (
      .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .iLAST(iLAST),
      .oREADY(ready_r), .iRDY(iRDY), .oWE(we_r),
      .oDATA_0(d0_r), .oDATA_1(d1_r), .oDATA_2(d2_r), .oDATA_3(d3_r),
      .oADDR_WR_0(a0_r), .oADDR_WR_1(a1_r), .oADDR_WR_2(a2_r), .oADDR_WR_3(a3_r),
      .oSTART(start_r), .oBUSY(busy_r), .oERR_LEN(err_r)
   );

   fht_stream_loader #(.D_BIT(16), .A_BIT(2), .BIT_REV(0)) u_nat (
      .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .iLAST(iLAST),
      .oREADY(ready_n), .iRDY(iRDY), .oWE(we_n),
      .oDATA_0(d0_n), .oDATA_1(d1_n), .oDATA_2(d2_n), .oDATA_3(d3_n),
      .oADDR_WR_0(a0_n), .oADDR_WR_1(a1_n), .oADDR_WR_2(a2_n), .oADDR_WR_3(a3_n),
      .oSTART(start_n), .oBUSY(busy_n), .oERR_LEN(err_n)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cyc++;

   always @(negedge iCLK) begin
      if (we_r != 4'b0) begin
         r_we.push_back(int'(we_r));
         r_addr.push_back(int'(a0_r));
         r_data.push_back(int'(d0_r));
         r_cyc.push_back(cyc);
         if (a1_r != a0_r || a2_r != a0_r || a3_r != a0_r ||
             d1_r != d0_r || d2_r != d0_r || d3_r != d0_r) fan_err++;
      end
      if (we_n != 4'b0) begin
         n_we.push_back(int'(we_n));
         n_addr.push_back(int'(a0_n));
         n_data.push_back(int'(d0_n));
      end
      if (start_r) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (err_r) err_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_we"}, int'(we_r), 0);
      check({tag, "_d"}, int'(d0_r) | int'(d1_r) | int'(d2_r) | int'(d3_r), 0);
      check({tag, "_a"}, int'(a0_r) | int'(a1_r) | int'(a2_r) | int'(a3_r), 0);
      check({tag, "_start"}, int'(start_r), 0);
      check({tag, "_busy"}, int'(busy_r), 0);
      check({tag, "_err"}, int'(err_r), 0);
      check({tag, "_ready"}, int'(ready_r), 1);
      check({tag, "_nat_we"}, int'(we_n), 0);
   endtask

   task automatic check_writes(input string tag, input int base, input int nvalid, input int dbase);
      int r, d;
      check({tag, "_nwr"}, r_we.size() - base, 16);
      check({tag, "_nwr_nat"}, n_we.size() - base, 16);
      if (r_we.size() - base >= 16 && n_we.size() - base >= 16) begin
         for (int i = 0; i < 16; i++) begin
            r = rev_tab[i];
            d = (i < nvalid) ? dbase + i : 0;
            check($sformatf("%s_we%0d", tag, i), r_we[base+i], 1 << (r % 4));
            check($sformatf("%s_addr%0d", tag, i), r_addr[base+i], r / 4);
            check($sformatf("%s_data%0d", tag, i), r_data[base+i], d);
            check($sformatf("%s_nwe%0d", tag, i), n_we[base+i], 1 << (i % 4));
            check($sformatf("%s_naddr%0d", tag, i), n_addr[base+i], i / 4);
            check($sformatf("%s_ndata%0d", tag, i), n_data[base+i], d);
         end
      end
   endtask

   task automatic wait_start(input string tag);
      for (int i = 0; i < 60; i++) begin
         step();
         if (start_r) break;
      end
      check({tag, "_start_seen"}, int'(start_r), 1);
   endtask

   // Called in the oSTART cycle: iRDY held from there on must only take effect two cycles later.
   task automatic release_guarded(input string tag);
      iRDY = 1'b1;
      step();
      check({tag, "_guard1_ready"}, int'(ready_r), 0);
      step();
      check({tag, "_guard2_ready"}, int'(ready_r), 0);
      check({tag, "_guard2_busy"}, int'(busy_r), 1);
      step();
      check({tag, "_rel_ready"}, int'(ready_r), 1);
      check({tag, "_rel_busy"}, int'(busy_r), 0);
      iRDY = 1'b0;
   endtask

   initial begin
      int base, s0, e0, k, bad, idle;
      logic rdy;
      iRESET = 1'b0;
      iDATA  = '0;
      iVALID = 1'b0;
      iLAST  = 1'b0;
      iRDY   = 1'b0;
      step();
      step();
      check_reset("rst0");
      iRESET = 1'b1;
      step();

      // Frame 1: full frame, back-to-back, iLAST on sample 16.
      base = r_we.size();
      e0 = err_cnt;
      s0 = start_cnt;
      for (int i = 0; i < 16; i++) begin
         iVALID = 1'b1;
         iDATA  = 16'(100 + i);
         iLAST  = (i == 15);
         check($sformatf("f1_ready%0d", i), int'(ready_r), 1);
         step();
      end
      iVALID = 1'b0;
      iLAST  = 1'b0;
      check("f1_busy_at_end", int'(busy_r), 1);
      wait_start("f1");
      for (int i = 0; i < 4; i++) begin
         step();
         check("f1_wait_ready", int'(ready_r), 0);
         check("f1_wait_busy", int'(busy_r), 1);
      end
      check("f1_start_lat", start_cyc - r_cyc[base+15], 1);
      check("f1_start_cnt", start_cnt - s0, 1);
      check("f1_err_cnt", err_cnt - e0, 0);
      iRDY = 1'b1;
      step();
      check("f1_rel_ready", int'(ready_r), 1);
      check("f1_rel_busy", int'(busy_r), 0);
      iRDY = 1'b0;
      check_writes("f1", base, 16, 100);

      // Frame 3: iLAST on sample 5, remainder zero-padded.
      base = r_we.size();
      e0 = err_cnt;
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) begin
         iVALID = 1'b1;
         iDATA  = 16'(100 + i);
         iLAST  = (i == 4);
         step();
      end
      iVALID = 1'b0;
      iLAST  = 1'b0;
      check("f3_err_now", int'(err_r), 1);
      step();
      check("f3_pad_ready", int'(ready_r), 0);
      check("f3_err_gone", int'(err_r), 0);
      wait_start("f3");
      check("f3_err_cnt", err_cnt - e0, 1);
      release_guarded("f3");
      check("f3_start_cnt", start_cnt - s0, 1);
      check_writes("f3", base, 5, 100);
      bad = 0;
      if (r_cyc.size() - base >= 16) begin
         for (int i = 1; i < 16; i++) if (r_cyc[base+i] - r_cyc[base+i-1] != 1) bad++;
      end
      check("f3_pad_consec", bad, 0);

      // Frame 4: 16 samples with no iLAST while iVALID stays high.
      base = r_we.size();
      e0 = err_cnt;
      s0 = start_cnt;
      k = 0;
      iVALID = 1'b1;
      iLAST  = 1'b0;
      iDATA  = 16'(200);
      for (int t = 0; t < 60 && k < 16; t++) begin
         rdy = ready_r;
         step();
         if (rdy) k++;
         iDATA = 16'(200 + k);
      end
      check("f4_accepted", k, 16);
      wait_start("f4");
      check("f4_err_cnt", err_cnt - e0, 1);
      check("f4_hold_ready", int'(ready_r), 0);
      release_guarded("f4");
      check("f4_start_cnt", start_cnt - s0, 1);
      check_writes("f4", base, 16, 200);
      base = r_we.size();
      for (int t = 0; t < 30 && k < 23; t++) begin
         rdy = ready_r;
         step();
         if (rdy) k++;
         iDATA = 16'(200 + k);
      end
      iVALID = 1'b0;
      step();
      check("f4_next_nwr", r_we.size() - base, 7);
      if (r_we.size() - base >= 7 && n_we.size() - base >= 7) begin
         check("f4_next_data", r_data[base], 216);
         check("f4_next_we", r_we[base], 1);
         check("f4_next_addr", r_addr[base], 0);
         check("f4_next_nwe", n_we[base], 1);
         check("f4_next_naddr", n_addr[base], 0);
         check("f4_seventh_we", r_we[base+6], 1 << (rev_tab[6] % 4));
         check("f4_seventh_addr", r_addr[base+6], rev_tab[6] / 4);
      end

      // Reset mid-frame after 7 samples.
      iRESET = 1'b0;
      step();
      check_reset("rst_mid");
      iRESET = 1'b1;
      s0 = start_cnt;
      repeat (10) step();
      check("rst_mid_no_start", start_cnt - s0, 0);

      // Frame 5: gapped valid, stray iLAST without valid, iRDY high during LOAD.
      base = r_we.size();
      e0 = err_cnt;
      iRDY = 1'b1;
      for (int i = 0; i < 16; i++) begin
         idle = $urandom_range(0, 2);
         for (int j = 0; j < idle; j++) begin
            iVALID = 1'b0;
            iLAST  = 1'b1;
            step();
         end
         iVALID = 1'b1;
         iDATA  = 16'(300 + i);
         iLAST  = (i == 15);
         check($sformatf("f5_ready%0d", i), int'(ready_r), 1);
         step();
      end
      iVALID = 1'b0;
      iLAST  = 1'b0;
      iRDY   = 1'b0;
      wait_start("f5");
      check("f5_err_cnt", err_cnt - e0, 0);
      check_writes("f5", base, 16, 300);

      // Reset while in WAIT, then a single sample must land at index 0.
      step();
      check("f5_wait_busy", int'(busy_r), 1);
      iRESET = 1'b0;
      step();
      check_reset("rst_wait");
      iRESET = 1'b1;
      s0 = start_cnt;
      base = r_we.size();
      iVALID = 1'b1;
      iDATA  = 16'(400);
      step();
      iVALID = 1'b0;
      repeat (20) step();
      check("post_rst_nwr", r_we.size() - base, 1);
      if (r_we.size() - base >= 1) begin
         check("post_rst_we", r_we[base], 1);
         check("post_rst_addr", r_addr[base], 0);
         check("post_rst_data", r_data[base], 400);
      end
      check("post_rst_no_start", start_cnt - s0, 0);
      check("bank_fanout", fan_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fht_stream_loader.md
Name: fht_stream_loader

Overview:
- Upstream feeder of the FHT core.
- Accepts a serial sample stream with a valid/ready handshake and scatters each frame of N = 4*2^A_BIT points across the core's four RAM(A) banks, using bit-reversed, bank-interleaved addressing.
- After the last write it issues a one-cycle start strobe to the core, then holds off new input until the core reports ready.
- Zero-pads short frames and flags length errors.

Parameters:
- D_BIT, 16, sample width; matches the core data width.
- A_BIT, 8, per-bank address width; frame length N = 2^(A_BIT+2).
- BIT_REV, 1: 1 = bit-reverse the point index before bank/address split; 0 = natural order.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  synchronous reset, active-low.
- iDATA  in  D_BIT  signed input sample.
- iVALID  in  1  sample valid.
- iLAST  in  1  marks the final sample of a frame; qualified by iVALID.
- oREADY  out  1  loader accepts a sample this cycle.
- iRDY  in  1  core done/ready (the core's oRDY).
- oWE  out  4  one-hot bank write enable to the core iWE.
- oDATA_0..oDATA_3  out  D_BIT each  write data, bank 0..3.
- oADDR_WR_0..oADDR_WR_3  out  A_BIT each  write address, bank 0..3.
- oSTART  out  1  one-cycle start strobe to the core.
- oBUSY  out  1  high from frame end until the core reports ready.
- oERR_LEN  out  1  one-cycle pulse on a frame-length error.

Behaviour:
- One clock domain, iCLK. Reset is synchronous and active-low on iRESET; it takes effect on the iCLK edge while iRESET=0.
- Reset values:
  - state=LOAD, point counter n=0.
  - oWE=0, all oDATA_x=0, all oADDR_WR_x=0.
  - oSTART=0, oBUSY=0, oERR_LEN=0.
- Index mapping, with N_BIT = A_BIT+2:
  - r = BIT_REV ? bitreverse(n over N_BIT bits) : n.
  - bank = r[1:0]; addr = r[N_BIT-1:2].
- All write-side outputs are registered, with 1-cycle latency from the accepting edge:
  - oWE = one-hot(bank).
  - All four oDATA_x = sample.
  - All four oADDR_WR_x = addr.
  - When no write is issued, oWE=0 and data/address hold their last values.
- oREADY is combinational: 1 iff state==LOAD. A sample is accepted when iVALID & oREADY; n increments on each accept.
- State LOAD:
  - Accept with iLAST=1 and n==N-1: normal end. Next state START.
  - Accept with iLAST=1 and n<N-1: early end. oERR_LEN pulses on the next cycle; next state PAD.
  - Accept with n==N-1 and iLAST=0: forced end. oERR_LEN pulses; next state START. The following samples belong to the next frame.
- State PAD: oREADY=0. Writes 0 to each remaining index n+1..N-1, one per cycle, using the same mapping. After index N-1 the next state is START.
- State START:
  - Entered only after the final write has been issued; oSTART=1 for exactly one cycle, on the cycle after the final write is visible on oWE.
  - n is cleared. Next state WAIT.
- State WAIT:
  - oBUSY=1, oREADY=0, oWE=0.
  - iRDY is ignored in the cycle oSTART is high and in the cycle after it.
  - From the third cycle after oSTART, iRDY=1 returns the block to LOAD, with oBUSY=0 on the next cycle.
- oBUSY is set on the cycle the frame-ending write is issued (LOAD end or PAD end) and cleared on leaving WAIT.
- iRDY in LOAD or PAD is ignored. iLAST without iVALID is ignored.
- Reset mid-frame or in WAIT: the partial frame is discarded and no oSTART is issued. The block returns to LOAD with n=0.
- No back-pressure exists on the write side; the core must accept one write per cycle.

Test Plan:
- A_BIT=2, BIT_REV=1, 16 samples 100..115 streamed back-to-back, iLAST on the 16th:
  - Writes go bank0 addr 0,2,1,3 for samples 100..103.
  - Sample 104 goes to bank2 addr0.
  - oSTART is high exactly 1 cycle after the 16th write.
  - oREADY=0 until iRDY is driven high, then oREADY=1 the next cycle.
- Same setup with BIT_REV=0:
  - Sample k goes to bank k%4, addr k/4.
  - oWE sequence is 0001,0010,0100,1000 repeating.
- Early iLAST on the 5th sample (A_BIT=2):
  - oERR_LEN pulses once.
  - 11 zero writes follow on consecutive cycles, covering all remaining indices with no duplicates.
  - oSTART then pulses once.
- 16 samples with no iLAST, then iVALID continues:
  - oERR_LEN pulses, oSTART fires, and oREADY stays 0 until iRDY.
  - The 17th sample is accepted as index 0 of the next frame.
- Gapped iVALID (random idle cycles) plus iRDY asserted during LOAD: mapping is unchanged and iRDY has no effect.
- iRESET=0 after 7 samples, and again during WAIT:
  - No oSTART is issued.
  - All outputs are at reset values the next cycle, and the next frame starts at index 0.
